multicycle_cpu: RTL and testbench

- 16-bit multi-cycle processor for the TSC ISA: 4 general registers, word-addressed 16-bit memory.
- Talks to an unclocked external memory over a shared bidirectional data bus with a readM/writeM/inputReady handshake.
- Exposes debug outputs: instruction count, WWD output port, halt flag.
- The companion memory model sits outside this block.

---
 rtl/tsc_pkg.sv | 53 +++++
 rtl/tsc_alu.sv | 35 +++
 rtl/multicycle_cpu.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared definitions for the TSC multi-cycle CPU: sizes, ISA encodings,
// control FSM states and the ALU operation set.
package tsc_pkg;

  localparam int WORD_SIZE = 16;
  localparam int NUM_REGS  = 4;

  localparam logic [1:0] LINK_REG = 2'd2;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_TCP, ALU_SHL, ALU_SHR,
    ALU_LHI, ALU_BEQ, ALU_BNE, ALU_BGZ, ALU_BLZ
  } alu_op_t;

  function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] imm);
    return {{(WORD_SIZE-8){imm[7]}}, imm};
  endfunction

  function automatic logic [WORD_SIZE-1:0] zext8(input logic [7:0] imm);
    return {{(WORD_SIZE-8){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/tsc_alu.sv
// Combinational ALU for the TSC CPU: arithmetic/logic result plus the
// branch-condition flag used by BEQ/BNE/BGZ/BLZ.
module tsc_alu
  import tsc_pkg::*;
(
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  alu_op_t              op,
  output logic [WORD_SIZE-1:0] result,
  output logic                 cond
);

  always_comb begin
    result = '0;
    cond   = 1'b0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOT: result = ~a;
      ALU_TCP: result = '0 - a;
      ALU_SHL: result = {a[WORD_SIZE-2:0], 1'b0};
      ALU_SHR: result = {a[WORD_SIZE-1], a[WORD_SIZE-1:1]};
      ALU_LHI: result = {b[7:0], {(WORD_SIZE-8){1'b0}}};
      ALU_BEQ: cond = (a == b);
      ALU_BNE: cond = (a != b);
      // signed compares reduce to sign bit and zero test
      ALU_BGZ: cond = !a[WORD_SIZE-1] && (a != '0);
      ALU_BLZ: cond = a[WORD_SIZE-1];
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// TSC ISA multi-cycle CPU: control FSM, 4-entry register file and a shared-bus
// memory handshake (request held until inputReady). ALU is tsc_alu.
//   state  | meaning
//   S_IF   | readM=1, address=PC; latch IR on inputReady
//   S_ID   | read rs/rt, compute PC+1
//   S_EX   | ALU / branch compare; branches, jumps, WWD, HLT finish here
//   S_MEM  | LWD reads / SWD writes at ALU address, wait for inputReady
//   S_WB   | register write, instruction completes
//   S_HALT | frozen after HLT until reset
module multicycle_cpu
  import tsc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [WORD_SIZE-1:0] output_port,
  output logic                 is_halted
);

  state_t state, state_next;
  logic   read_next, write_next, complete;

  logic [WORD_SIZE-1:0] pc, ir, a_val, b_val, pc_inc, alu_q, mdr;
  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  logic [3:0]  opcode;
  logic [1:0]  rs, rt, rd;
  logic [5:0]  func;
  logic [7:0]  imm8;
  logic [11:0] target;

  assign opcode = ir[15:12];
  assign rs     = ir[11:10];
  assign rt     = ir[9:8];
  assign rd     = ir[7:6];
  assign func   = ir[5:0];
  assign imm8   = ir[7:0];
  assign target = ir[11:0];

  logic is_rtype, is_branch, is_load, is_store, is_imm_alu, is_r_alu;
  logic is_jump, is_jreg, is_link, is_wwd, is_hlt;

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_branch  = opcode inside {OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ};
  assign is_load    = (opcode == OP_LWD);
  assign is_store   = (opcode == OP_SWD);
  assign is_imm_alu = opcode inside {OP_ADI, OP_ORI, OP_LHI};
  assign is_r_alu   = is_rtype && (func inside {[FN_ADD:FN_SHR]});
  assign is_jump    = opcode inside {OP_JMP, OP_JAL};
  assign is_jreg    = is_rtype && (func inside {FN_JPR, FN_JRL});
  assign is_link    = (opcode == OP_JAL) || (is_rtype && func == FN_JRL);
  assign is_wwd     = is_rtype && (func == FN_WWD);
  assign is_hlt     = is_rtype && (func == FN_HLT);

  alu_op_t              alu_op;
  logic [WORD_SIZE-1:0] alu_b, alu_res, pc_target;
  logic                 alu_cond;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b_val;
    case (opcode)
      OP_BNE: alu_op = ALU_BNE;
      OP_BEQ: alu_op = ALU_BEQ;
      OP_BGZ: alu_op = ALU_BGZ;
      OP_BLZ: alu_op = ALU_BLZ;
      OP_ADI, OP_LWD, OP_SWD: alu_b = sext8(imm8);
      OP_ORI: begin
        alu_op = ALU_OR;
        alu_b  = zext8(imm8);
      end
      OP_LHI: begin
        alu_op = ALU_LHI;
        alu_b  = zext8(imm8);
      end
      OP_RTYPE: begin
        case (func)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_ORR:  alu_op = ALU_OR;
          FN_NOT:  alu_op = ALU_NOT;
          FN_TCP:  alu_op = ALU_TCP;
          FN_SHL:  alu_op = ALU_SHL;
          FN_SHR:  alu_op = ALU_SHR;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  tsc_alu u_alu (
    .a      (a_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .cond   (alu_cond)
  );

  always_comb begin
    pc_target = pc_inc;
    if (is_branch && alu_cond) pc_target = pc_inc + sext8(imm8);
    else if (is_jump)          pc_target = {pc[WORD_SIZE-1:12], target};
    else if (is_jreg)          pc_target = a_val;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IF:  if (readM && inputReady) state_next = S_ID;
      S_ID:  state_next = S_EX;
      S_EX: begin
        if (is_load || is_store)        state_next = S_MEM;
        else if (is_imm_alu || is_r_alu) state_next = S_WB;
        else if (is_hlt)                state_next = S_HALT;
        else                            state_next = S_IF;
      end
      S_MEM: if ((readM || writeM) && inputReady) state_next = is_load ? S_WB : S_IF;
      S_WB:   state_next = S_IF;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IF;
    endcase
    // requests are registered so they start cleanly after reset and drop with it
    read_next  = (state_next == S_IF) || (state_next == S_MEM && is_load);
    write_next = (state_next == S_MEM) && is_store;
    complete   = (state inside {S_EX, S_MEM, S_WB}) &&
                 (state_next inside {S_IF, S_HALT});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IF;
      readM  <= 1'b0;
      writeM <= 1'b0;
    end else begin
      state  <= state_next;
      readM  <= read_next;
      writeM <= write_next;
    end
  end

  assign address = (state == S_MEM) ? alu_q : pc;
  assign data    = writeM ? b_val : 'z;

  logic                 reg_we;
  logic [1:0]           reg_wa;
  logic [WORD_SIZE-1:0] reg_wd;

  always_comb begin
    reg_we = 1'b0;
    reg_wa = rt;
    reg_wd = alu_q;
    if (state == S_WB) begin
      reg_we = 1'b1;
      reg_wa = is_rtype ? rd : rt;
      reg_wd = is_load ? mdr : alu_q;
    end else if (state == S_EX && is_link) begin
      reg_we = 1'b1;
      reg_wa = LINK_REG;
      reg_wd = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      ir          <= '0;
      a_val       <= '0;
      b_val       <= '0;
      pc_inc      <= '0;
      alu_q       <= '0;
      mdr         <= '0;
      num_inst    <= '0;
      output_port <= '0;
      is_halted   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == S_IF && readM && inputReady) ir <= data;
      if (state == S_ID) begin
        a_val  <= regs[rs];
        b_val  <= regs[rt];
        pc_inc <= pc + 1'b1;
      end
      if (state == S_EX) alu_q <= alu_res;
      if (state == S_MEM && readM && inputReady) mdr <= data;
      if (reg_we) regs[reg_wa] <= reg_wd;
      if (complete) begin
        pc       <= pc_target;
        num_inst <= num_inst + 1'b1;
      end
      if (state == S_EX && is_wwd) output_port <= a_val;
      if (state == S_EX && is_hlt) is_halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: an ISA-level interpreter predicts every
// completion; a monitor compares num_inst/output_port/is_halted as they change.
module tb_multicycle_cpu;

  logic        clk;
  logic        reset_n;
  logic        readM, writeM, inputReady, is_halted;
  logic [15:0] address, num_inst, output_port;
  wire  [15:0] data;

  logic        mem_drive;
  logic [15:0] mem_rdata;
  assign data = mem_drive ? mem_rdata : 16'hzzzz;

  multicycle_cpu dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .readM       (readM),
    .writeM      (writeM),
    .address     (address),
    .data        (data),
    .inputReady  (inputReady),
    .num_inst    (num_inst),
    .output_port (output_port),
    .is_halted   (is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    logic [15:0] o;
    logic        h;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem  [0:65535];
  logic [15:0] mmem [0:65535];
  int          checks = 0;
  int          passes = 0;
  int          proto_err = 0;
  int          model_count = 0;
  bit          mon_en = 1'b1;
  bit          mem_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic logic [15:0] r_ins(input int s, input int t, input int d, input int fn);
    return {4'hF, s[1:0], t[1:0], d[1:0], fn[5:0]};
  endfunction

  function automatic logic [15:0] i_ins(input int op, input int s, input int t, input int imm);
    return {op[3:0], s[1:0], t[1:0], imm[7:0]};
  endfunction

  function automatic logic [15:0] j_ins(input int op, input int tgt);
    return {op[3:0], tgt[11:0]};
  endfunction

  // Instruction-level interpreter over its own copy of memory.
  task automatic run_model();
    logic [15:0] r [4];
    logic [15:0] pc, npc, ins, imm_s, outp, cnt;
    bit          halted;
    int          op, s, t, d, fn;
    exp_t        e;
    for (int i = 0; i < 4; i++) r[i] = 16'h0;
    pc = 0; cnt = 0; outp = 0; halted = 0;
    for (int step = 0; step < 5000 && !halted; step++) begin
      ins   = mmem[pc];
      op    = int'(ins[15:12]);
      s     = int'(ins[11:10]);
      t     = int'(ins[9:8]);
      d     = int'(ins[7:6]);
      fn    = int'(ins[5:0]);
      imm_s = {{8{ins[7]}}, ins[7:0]};
      npc   = pc + 16'd1;
      case (op)
        0:  if (r[s] != r[t]) npc = pc + 16'd1 + imm_s;
        1:  if (r[s] == r[t]) npc = pc + 16'd1 + imm_s;
        2:  if ($signed(r[s]) > 0) npc = pc + 16'd1 + imm_s;
        3:  if ($signed(r[s]) < 0) npc = pc + 16'd1 + imm_s;
        4:  r[t] = r[s] + imm_s;
        5:  r[t] = r[s] | {8'h00, ins[7:0]};
        6:  r[t] = {ins[7:0], 8'h00};
        7:  r[t] = mmem[r[s] + imm_s];
        8:  mmem[r[s] + imm_s] = r[t];
        9:  npc = {pc[15:12], ins[11:0]};
        10: begin npc = {pc[15:12], ins[11:0]}; r[2] = pc + 16'd1; end
        15: case (fn)
          0:  r[d] = r[s] + r[t];
          1:  r[d] = r[s] - r[t];
          2:  r[d] = r[s] & r[t];
          3:  r[d] = r[s] | r[t];
          4:  r[d] = ~r[s];
          5:  r[d] = 16'd0 - r[s];
          6:  r[d] = r[s] << 1;
          7:  r[d] = $signed(r[s]) >>> 1;
          25: npc = r[s];
          26: begin npc = r[s]; r[2] = pc + 16'd1; end
          28: outp = r[s];
          29: halted = 1;
          default: ;
        endcase
        default: ;
      endcase
      pc  = npc;
      cnt = cnt + 16'd1;
      e.n = cnt; e.o = outp; e.h = halted;
      exp_q.push_back(e);
    end
    model_count = int'(cnt);
  endtask

  task automatic build_program();
    int a, sel, s, t, d, imm, dst;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[0]  = i_ins(6, 0, 0, 8'h12);
    mem[1]  = i_ins(5, 0, 0, 8'h34);
    mem[2]  = r_ins(0, 0, 0, 28);
    mem[3]  = i_ins(6, 0, 0, 0);
    mem[4]  = i_ins(4, 0, 1, -2);
    mem[5]  = r_ins(1, 0, 0, 28);
    mem[6]  = r_ins(1, 0, 2, 5);
    mem[7]  = r_ins(2, 0, 0, 28);
    mem[8]  = i_ins(5, 0, 3, 8'h80);
    mem[9]  = i_ins(8, 3, 1, 0);
    mem[10] = i_ins(7, 3, 3, 0);
    mem[11] = r_ins(3, 0, 0, 28);
    mem[12] = i_ins(1, 1, 3, 2);
    mem[13] = r_ins(0, 0, 0, 28);
    mem[14] = r_ins(0, 0, 0, 28);
    mem[15] = i_ins(3, 0, 0, 3);
    mem[16] = r_ins(2, 0, 0, 28);
    mem[17] = j_ins(10, 20);
    mem[18] = r_ins(1, 0, 0, 28);
    mem[19] = j_ins(9, 22);
    mem[20] = r_ins(0, 0, 0, 28);
    mem[21] = r_ins(2, 0, 0, 25);
    mem[22] = i_ins(0, 1, 2, 1);
    mem[23] = r_ins(1, 0, 0, 28);
    mem[24] = i_ins(2, 2, 0, 1);
    mem[25] = r_ins(0, 0, 0, 28);
    mem[26] = i_ins(5, 0, 0, 29);
    mem[27] = r_ins(0, 0, 0, 26);
    mem[28] = r_ins(2, 0, 0, 28);
    mem[29] = r_ins(2, 0, 0, 28);
    a = 30;
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 10));
      s   = int'($urandom_range(0, 3));
      t   = int'($urandom_range(0, 3));
      d   = int'($urandom_range(0, 3));
      imm = int'($urandom_range(0, 255));
      if (sel < 8) begin
        mem[a] = r_ins(s, t, d, sel);
        dst = d;
      end else begin
        mem[a] = i_ins(sel - 4, s, t, imm);
        dst = t;
      end
      mem[a+1] = r_ins(dst, 0, 0, 28);
      a = a + 2;
    end
    mem[a] = r_ins(0, 0, 0, 29);
    for (int i = 0; i < 65536; i++) mmem[i] = mem[i];
  endtask

  // Memory: responds after a random number of cycles, driving inputReady at negedge.
  initial begin
    int wait_cnt;
    inputReady = 1'b0;
    mem_drive  = 1'b0;
    mem_rdata  = 16'h0;
    wait_cnt   = int'($urandom_range(0, 4));
    forever begin
      @(negedge clk);
      if (inputReady) begin
        inputReady = 1'b0;
        mem_drive  = 1'b0;
        wait_cnt   = int'($urandom_range(0, 4));
      end else if ((readM || writeM) && !mem_stall) begin
        if (wait_cnt == 0) begin
          if (writeM) mem[address] = data;
          else begin
            mem_rdata = mem[address];
            mem_drive = 1'b1;
          end
          inputReady = 1'b1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: pops a prediction on every num_inst change and checks handshake rules.
  initial begin
    exp_t        e;
    logic [15:0] last_num, last_out;
    bit          rd_prev, wr_prev;
    last_num = 0; last_out = 0; rd_prev = 0; wr_prev = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || !mon_en) begin
        rd_prev = 0;
        wr_prev = 0;
      end else begin
        if (readM && writeM) proto_err++;
        if (rd_prev && !inputReady && !readM) proto_err++;
        if (wr_prev && !inputReady && !writeM) proto_err++;
        if (rd_prev && inputReady && readM) proto_err++;
        if (wr_prev && inputReady && writeM) proto_err++;
        if (num_inst != last_num) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'(num_inst), 32'(last_num));
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("inst%0d_count", e.n), 32'(num_inst), 32'(e.n));
            chk($sformatf("inst%0d_output", e.n), 32'(output_port), 32'(e.o));
            chk($sformatf("inst%0d_halted", e.n), 32'(is_halted), 32'(e.h));
          end
          last_num = num_inst;
          last_out = output_port;
        end else if (output_port != last_out) begin
          proto_err++;
        end
        rd_prev = readM;
        wr_prev = writeM;
      end
    end
  end

  initial begin
    bit found;
    int req_after_halt;
    reset_n = 1'b0;
    build_program();
    run_model();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_readM", 32'(readM), 0);
    chk("reset_writeM", 32'(writeM), 0);
    chk("reset_num_inst", 32'(num_inst), 0);
    chk("reset_output_port", 32'(output_port), 0);
    chk("reset_is_halted", 32'(is_halted), 0);
    chk("reset_address", 32'(address), 0);

    @(negedge clk);
    reset_n = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #2;
      if (readM) found = 1;
    end
    chk("first_fetch_seen", 32'(found), 1);
    chk("first_fetch_addr", 32'(address), 0);

    for (int c = 0; c < 20000 && !is_halted; c++) @(posedge clk);
    #2;
    chk("halt_within_budget", 32'(is_halted), 1);

    req_after_halt = 0;
    repeat (100) begin
      @(posedge clk);
      #2;
      if (readM || writeM) req_after_halt++;
    end
    chk("no_request_after_halt", 32'(req_after_halt), 0);
    chk("num_inst_frozen", 32'(num_inst), 32'(model_count));
    chk("still_halted", 32'(is_halted), 1);
    chk("predictions_drained", 32'(exp_q.size()), 0);
    chk("store_roundtrip_mem", 32'(mem[16'h0080]), 32'(mmem[16'h0080]));
    chk("handshake_protocol", 32'(proto_err), 0);

    mon_en    = 1'b0;
    mem_stall = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #2;
      if (readM) found = 1;
    end
    chk("refetch_seen", 32'(found), 1);
    chk("refetch_addr", 32'(address), 0);
    repeat (3) @(posedge clk);
    #2;
    chk("readM_held_while_waiting", 32'(readM), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_readM", 32'(readM), 0);
    chk("abort_num_inst", 32'(num_inst), 0);
    chk("abort_output_port", 32'(output_port), 0);
    chk("abort_is_halted", 32'(is_halted), 0);
    #5;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("after_abort_addr", 32'(address), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
